mc_mem_arbiter: RTL and testbench
=================================

# mc_mem_arbiter

Two-requester arbiter and access sequencer for the single shared memory of the multicycle RISC-V core. Requester 0 is the core's memory port, used for fetch and load/store. Requester 1 is the program loader/debug port. The block serialises requests onto one synchronous memory with a fixed read latency. It grants with round-robin fairness and returns read data or write completion through a registered valid pulse.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 2, memory read latency in cycles, legal range 1..15
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- m0_req / m1_req  in  1  request; held with we/addr/wdata until the matching gnt is seen
- m0_we / m1_we  in  1  1 = write, 0 = read
- m0_addr / m1_addr  in  AW  address
- m0_wdata / m1_wdata  in  DW  write data
- m0_gnt / m1_gnt  out  1  one-cycle grant pulse; request is captured
- m0_rvalid / m1_rvalid  out  1  one-cycle completion pulse (read or write)
- m0_rdata / m1_rdata  out  DW  read data, valid with rvalid, held until that requester's next read
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states:
  - IDLE: sample requests. If any request is present, latch the winner's owner, we, addr and wdata, then go to ISSUE.
  - ISSUE: mem_en=1 and gnt=1 to the owner. Load the wait counter with MEM_LAT. Go to WAIT.
  - WAIT: decrement the counter each cycle. On the cycle the counter equals 1, capture mem_rdata (reads only), then go to RESP.
  - RESP: owner's rvalid=1. Go to IDLE.
- Arbitration happens only in IDLE.
  - A single requester always wins.
  - When both request, the winner is the requester that is not last_owner. last_owner updates on entering ISSUE.
  - last_owner resets to 1, so m0 wins the first tie.
- mem_addr, mem_wdata and the we value come from the latched registers. mem_en and mem_we are asserted only in ISSUE (mem_we = latched we & ISSUE).
- Requests are not queued.
  - A req that drops before IDLE samples it is lost, with no error.
  - Request inputs are ignored in ISSUE, WAIT and RESP.
- Write completion: rvalid pulses and rdata is left unchanged.
- All outputs are registered or decoded from state only (Moore); no input-to-output combinational path.

## Timing
- Reference cycle T = IDLE cycle in which the request is sampled:
  - T+1: ISSUE.
  - T+2 .. T+1+MEM_LAT: WAIT, for MEM_LAT cycles.
  - T+1+MEM_LAT: mem_rdata sampled.
  - T+2+MEM_LAT: RESP, rvalid high.
  - T+3+MEM_LAT: IDLE again.
- Throughput: one access per MEM_LAT+3 cycles.
- Reset, whether idle or mid-transaction:
  - Immediately: state=IDLE, all outputs 0, m0/m1_rdata=0, counter=0, last_owner=1.
  - An in-flight transaction is dropped with no rvalid.
  - The first IDLE sample occurs on the first rising edge after rst goes high.
- Continuous dual requests alternate strictly: m0, m1, m0, …
- A requester re-requesting in the same cycle as its own rvalid is sampled in the following IDLE cycle.

## Test plan
- MEM_LAT=2, reset released, m0 read of 0x10 sampled at cycle 0:
  - cycle 1: m0_gnt=1, mem_en=1, mem_we=0, mem_addr=0x10.
  - cycle 3: memory drives 0xDEADBEEF.
  - cycle 4: m0_rvalid=1, m0_rdata=0xDEADBEEF.
  - busy high cycles 1-4.
- m1 write of addr 0x20, wdata 0x55:
  - cycle 1: m1_gnt=1, mem_we=1, mem_wdata=0x55.
  - cycle 4: m1_rvalid=1; m1_rdata unchanged; m0 outputs stay 0.
- Both requesters held high from reset release: grants m0@1, m1@6, m0@11, m1@16; each rvalid 3 cycles after its gnt.
- rst driven low during WAIT:
  - Same cycle: all outputs 0, busy=0, no rvalid ever for the dropped access.
  - After release, a simultaneous m0+m1 request grants m0 first.
- MEM_LAT=1 instance, m0 read at cycle 0: mem_en cycle 1, data sampled cycle 2, m0_rvalid cycle 3, next grant possible cycle 5.
- m1_req asserted only during ISSUE/WAIT of an m0 access and dropped before IDLE: no m1_gnt and no mem_en for m1.

Source files
------------

// File: rtl/mc_mem_arbiter_if.sv
// Bus bundle for mc_mem_arbiter: both requester ports plus the shared
// synchronous memory port. The arbiter connects through the slave modport;
// whatever drives the requests and models the memory uses master.
interface mc_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mc_mem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the core's
// single shared synchronous memory (fixed read latency MEM_LAT, 1..15).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sample requests, latch the winner's access
// ISSUE | mem_en strobe and grant pulse to the owner, load wait counter
// WAIT  | count down the memory latency, capture read data at count 1
// RESP  | completion pulse (rvalid) to the owner
//
// All outputs are registered; requests only matter in IDLE. last_owner
// doubles as the owner of the access in flight, since it is updated on the
// same edge that the access is accepted.
module mc_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    mc_mem_arbiter_if.slave bus,
    output logic            busy
);
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          last_owner;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [3:0]    cnt;

    logic          win;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not go last.
    always_comb begin
        if (bus.m0_req && bus.m1_req) begin
            win = ~last_owner;
        end else begin
            win = bus.m1_req;
        end
        win_we    = win ? bus.m1_we    : bus.m0_we;
        win_addr  = win ? bus.m1_addr  : bus.m0_addr;
        win_wdata = win ? bus.m1_wdata : bus.m0_wdata;
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    // Sequencer FSM with registered strobes, pulses and per-requester read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            last_owner    <= 1'b1;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cnt           <= 4'd0;
            busy          <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.m0_gnt    <= 1'b0;
            bus.m1_gnt    <= 1'b0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m0_rdata  <= '0;
            bus.m1_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m0_req || bus.m1_req) begin
                        last_owner <= win;
                        we_q       <= win_we;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        bus.mem_en <= 1'b1;
                        bus.mem_we <= win_we;
                        bus.m0_gnt <= ~win;
                        bus.m1_gnt <= win;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    bus.m0_gnt <= 1'b0;
                    bus.m1_gnt <= 1'b0;
                    cnt        <= LAT;
                    state      <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        // Writes complete without touching the requester's rdata.
                        if (!we_q) begin
                            if (last_owner) begin
                                bus.m1_rdata <= bus.mem_rdata;
                            end else begin
                                bus.m0_rdata <= bus.mem_rdata;
                            end
                        end
                        bus.m0_rvalid <= ~last_owner;
                        bus.m1_rvalid <= last_owner;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.m0_rvalid <= 1'b0;
                    bus.m1_rvalid <= 1'b0;
                    busy          <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mc_mem_arbiter.sv
// Bench for mc_mem_arbiter: one instance with MEM_LAT=2 and one with
// MEM_LAT=1, each with its own memory responder and transaction-timing model.
module tb_mc_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic        m_req  [2][2];
    logic        m_we   [2][2];
    logic [31:0] m_addr [2][2];
    logic [31:0] m_wd   [2][2];

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] init_word(input int a);
        if (a == 16) return 32'hDEADBEEF;
        return 32'h1000_0000 + 32'(a) * 32'h0000_0101;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : env
        localparam int L = (g == 0) ? 2 : 1;

        mc_mem_arbiter_if #(.AW(32), .DW(32)) bus ();
        logic busy;

        mc_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
            .clk  (clk),
            .rst  (rst),
            .bus  (bus),
            .busy (busy)
        );

        assign bus.m0_req   = m_req[g][0];
        assign bus.m0_we    = m_we[g][0];
        assign bus.m0_addr  = m_addr[g][0];
        assign bus.m0_wdata = m_wd[g][0];
        assign bus.m1_req   = m_req[g][1];
        assign bus.m1_we    = m_we[g][1];
        assign bus.m1_addr  = m_addr[g][1];
        assign bus.m1_wdata = m_wd[g][1];

        // memory responder: data for a read appears L cycles after its mem_en cycle
        logic [31:0] em [256];
        int          due = -10;
        logic [7:0]  da = 8'd0;
        logic [31:0] rd_drv = 32'd0;
        assign bus.mem_rdata = rd_drv;

        initial begin
            for (int a = 0; a < 256; a++) em[a] = init_word(a);
            forever begin
                @(negedge clk);
                if (bus.mem_en === 1'b1) begin
                    if (bus.mem_we) em[bus.mem_addr[7:0]] = bus.mem_wdata;
                    else begin
                        due = cyc + L;
                        da  = bus.mem_addr[7:0];
                    end
                end
            end
        end

        initial forever begin
            @(posedge clk);
            #1;
            rd_drv = (cyc == due) ? em[da] : (32'hBAD0_0000 ^ 32'(cyc));
        end

        // model: age counts cycles since the sample edge (-1 = nothing in flight)
        int          age = -1;
        bit          own = 1'b0;
        bit          lo = 1'b1;
        bit          mwe = 1'b0;
        logic [31:0] maddr = 32'd0;
        logic [31:0] mwd = 32'd0;
        logic [31:0] erd [2];
        logic [31:0] mm [256];

        initial begin
            erd[0] = 32'd0;
            erd[1] = 32'd0;
            for (int a = 0; a < 256; a++) mm[a] = init_word(a);
            forever begin
                @(posedge clk or negedge rst);
                if (!rst) begin
                    age = -1; lo = 1'b1; own = 1'b0; mwe = 1'b0;
                    maddr = 32'd0; mwd = 32'd0; erd[0] = 32'd0; erd[1] = 32'd0;
                end else if (age >= 0) begin
                    if (age == 1 + L && !mwe) erd[own] = mm[maddr[7:0]];
                    age++;
                    if (age == 3 + L) age = -1;
                end else if (bus.m0_req || bus.m1_req) begin
                    own   = (bus.m0_req && bus.m1_req) ? !lo : bus.m1_req;
                    lo    = own;
                    mwe   = own ? bus.m1_we : bus.m0_we;
                    maddr = own ? bus.m1_addr : bus.m0_addr;
                    mwd   = own ? bus.m1_wdata : bus.m0_wdata;
                    if (mwe) mm[maddr[7:0]] = mwd;
                    age = 1;
                end
            end
        end

        // every-cycle comparison against the model
        initial forever begin
            @(negedge clk);
            check($sformatf("i%0d m0_gnt", g),    32'(bus.m0_gnt),    32'(age == 1 && !own));
            check($sformatf("i%0d m1_gnt", g),    32'(bus.m1_gnt),    32'(age == 1 && own));
            check($sformatf("i%0d m0_rvalid", g), 32'(bus.m0_rvalid), 32'(age == 2 + L && !own));
            check($sformatf("i%0d m1_rvalid", g), 32'(bus.m1_rvalid), 32'(age == 2 + L && own));
            check($sformatf("i%0d m0_rdata", g),  bus.m0_rdata,       erd[0]);
            check($sformatf("i%0d m1_rdata", g),  bus.m1_rdata,       erd[1]);
            check($sformatf("i%0d mem_en", g),    32'(bus.mem_en),    32'(age == 1));
            check($sformatf("i%0d mem_we", g),    32'(bus.mem_we),    32'(age == 1 && mwe));
            check($sformatf("i%0d mem_addr", g),  bus.mem_addr,       maddr);
            check($sformatf("i%0d mem_wdata", g), bus.mem_wdata,      mwd);
            check($sformatf("i%0d busy", g),      32'(busy),          32'(age >= 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input int p, input logic we,
                           input logic [31:0] a, input logic [31:0] d);
        m_req[i][p]  = 1'b1;
        m_we[i][p]   = we;
        m_addr[i][p] = a;
        m_wd[i][p]   = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int seen;
        int waited;
        for (int i = 0; i < 2; i++) begin
            for (int p = 0; p < 2; p++) begin
                m_req[i][p] = 1'b0; m_we[i][p] = 1'b0;
                m_addr[i][p] = 32'd0; m_wd[i][p] = 32'd0;
            end
        end
        #1 rst = 1'b0;

        // reset state
        repeat (3) tick();
        mid();
        check("rst busy", 32'(env[0].busy), 32'd0);
        check("rst m0_rdata", env[0].bus.m0_rdata, 32'd0);
        check("rst mem_en", 32'(env[0].bus.mem_en), 32'd0);
        check("rst m1_rvalid", 32'(env[0].bus.m1_rvalid), 32'd0);

        // m0 read of 0x10 sampled at cycle 0 (the reset-release cycle)
        tick();
        rst = 1'b1;
        set_req(0, 0, 1'b0, 32'h10, 32'h0);
        tick();
        m_req[0][0] = 1'b0;
        mid();
        check("A1 m0_gnt", 32'(env[0].bus.m0_gnt), 32'd1);
        check("A1 mem_en", 32'(env[0].bus.mem_en), 32'd1);
        check("A1 mem_we", 32'(env[0].bus.mem_we), 32'd0);
        check("A1 mem_addr", env[0].bus.mem_addr, 32'h10);
        check("A1 busy", 32'(env[0].busy), 32'd1);
        repeat (3) tick();
        mid();
        check("A4 m0_rvalid", 32'(env[0].bus.m0_rvalid), 32'd1);
        check("A4 m0_rdata", env[0].bus.m0_rdata, 32'hDEADBEEF);
        check("A4 busy", 32'(env[0].busy), 32'd1);
        tick();
        mid();
        check("A5 busy", 32'(env[0].busy), 32'd0);

        // m1 write 0x55 to 0x20, then m0 reads it back
        set_req(0, 1, 1'b1, 32'h20, 32'h55);
        tick();
        m_req[0][1] = 1'b0;
        mid();
        check("B1 m1_gnt", 32'(env[0].bus.m1_gnt), 32'd1);
        check("B1 m0_gnt", 32'(env[0].bus.m0_gnt), 32'd0);
        check("B1 mem_we", 32'(env[0].bus.mem_we), 32'd1);
        check("B1 mem_wdata", env[0].bus.mem_wdata, 32'h55);
        repeat (3) tick();
        mid();
        check("B4 m1_rvalid", 32'(env[0].bus.m1_rvalid), 32'd1);
        check("B4 m1_rdata", env[0].bus.m1_rdata, 32'd0);
        check("B4 m0_rvalid", 32'(env[0].bus.m0_rvalid), 32'd0);
        tick();
        set_req(0, 0, 1'b0, 32'h20, 32'h0);
        tick();
        m_req[0][0] = 1'b0;
        repeat (3) tick();
        mid();
        check("B readback m0_rvalid", 32'(env[0].bus.m0_rvalid), 32'd1);
        check("B readback m0_rdata", env[0].bus.m0_rdata, 32'h55);
        tick();

        // both requesters held from reset release: strict alternation
        rst = 1'b0;
        tick();
        set_req(0, 0, 1'b0, 32'h30, 32'h0);
        set_req(0, 1, 1'b0, 32'h40, 32'h0);
        rst = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (n == 20) begin
                m_req[0][0] = 1'b0;
                m_req[0][1] = 1'b0;
            end
            mid();
            if (n == 1 || n == 11) check($sformatf("C%0d m0_gnt", n), 32'(env[0].bus.m0_gnt), 32'd1);
            if (n == 6 || n == 16) check($sformatf("C%0d m1_gnt", n), 32'(env[0].bus.m1_gnt), 32'd1);
            if (n == 4 || n == 14) check($sformatf("C%0d m0_rvalid", n), 32'(env[0].bus.m0_rvalid), 32'd1);
            if (n == 9 || n == 19) check($sformatf("C%0d m1_rvalid", n), 32'(env[0].bus.m1_rvalid), 32'd1);
        end

        // reset during WAIT of an m0 read, then a tie must go to m0
        set_req(0, 0, 1'b0, 32'h50, 32'h0);
        tick();
        m_req[0][0] = 1'b0;
        tick();
        rst = 1'b0;
        mid();
        check("D busy", 32'(env[0].busy), 32'd0);
        check("D mem_addr", env[0].bus.mem_addr, 32'd0);
        check("D m0_rdata", env[0].bus.m0_rdata, 32'd0);
        for (int n = 0; n < 4; n++) begin
            tick();
            mid();
            check("D dropped m0_rvalid", 32'(env[0].bus.m0_rvalid), 32'd0);
        end
        tick();
        set_req(0, 0, 1'b0, 32'h30, 32'h0);
        set_req(0, 1, 1'b0, 32'h40, 32'h0);
        rst = 1'b1;
        tick();
        mid();
        check("D tie m0_gnt", 32'(env[0].bus.m0_gnt), 32'd1);
        check("D tie m1_gnt", 32'(env[0].bus.m1_gnt), 32'd0);
        m_req[0][0] = 1'b0;
        seen = 0;
        waited = 0;
        while (!seen && waited < 10) begin
            tick();
            waited++;
            mid();
            if (env[0].bus.m1_gnt === 1'b1) seen = 1;
        end
        check("D m1_gnt seen", 32'(seen), 32'd1);
        check("D m1_gnt delay", 32'(waited), 32'd5);
        m_req[0][1] = 1'b0;
        repeat (5) tick();

        // m1 request only while m0 access is in flight: lost
        set_req(0, 0, 1'b0, 32'h10, 32'h0);
        tick();
        m_req[0][0] = 1'b0;
        set_req(0, 1, 1'b0, 32'h24, 32'h0);
        repeat (3) tick();
        m_req[0][1] = 1'b0;
        seen = 0;
        for (int n = 0; n < 7; n++) begin
            mid();
            if (env[0].bus.m1_gnt === 1'b1) seen++;
            tick();
        end
        check("F lost m1_gnt count", 32'(seen), 32'd0);

        // MEM_LAT=1 instance, with re-request in the rvalid cycle
        set_req(1, 0, 1'b0, 32'h10, 32'h0);
        tick();
        m_req[1][0] = 1'b0;
        mid();
        check("E1 mem_en", 32'(env[1].bus.mem_en), 32'd1);
        check("E1 m0_gnt", 32'(env[1].bus.m0_gnt), 32'd1);
        tick();
        mid();
        check("E2 m0_rvalid", 32'(env[1].bus.m0_rvalid), 32'd0);
        tick();
        mid();
        check("E3 m0_rvalid", 32'(env[1].bus.m0_rvalid), 32'd1);
        check("E3 m0_rdata", env[1].bus.m0_rdata, 32'hDEADBEEF);
        set_req(1, 0, 1'b0, 32'h14, 32'h0);
        tick();
        mid();
        check("E4 busy", 32'(env[1].busy), 32'd0);
        check("E4 m0_gnt", 32'(env[1].bus.m0_gnt), 32'd0);
        tick();
        m_req[1][0] = 1'b0;
        mid();
        check("E5 m0_gnt", 32'(env[1].bus.m0_gnt), 32'd1);
        check("E5 mem_addr", env[1].bus.mem_addr, 32'h14);
        repeat (2) tick();
        mid();
        check("E7 m0_rvalid", 32'(env[1].bus.m0_rvalid), 32'd1);
        check("E7 m0_rdata", env[1].bus.m0_rdata, 32'h1000_1414);

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
